// File: rtl/gol_sequencer_if.sv
// gol_sequencer_if: frame handshake between the sequencer and the display side
interface gol_sequencer_if;
  logic [63:0] grid;
  logic        frame_valid;
  logic        frame_ready;
  modport master (output grid, frame_valid, input frame_ready);
  modport slave  (input grid, frame_valid, output frame_ready);
endinterface

// File: rtl/gol_sequencer.sv
// gol_sequencer: seeds, evolves, presents and terminates the 8x8 Game of Life board
module gol_sequencer #(
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    max_gen,
  input  logic [63:0]         lfsr_out,
  output logic                lfsr_reset,
  input  logic [63:0]         grid_next,
  gol_sequencer_if.master     frame,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy,
  output logic                done,
  output logic [1:0]          done_cause
);
  typedef enum logic [2:0] {IDLE, SEED, LOAD, PRESENT, CHECK, WAIT, EVOLVE, DONE} state_t;
  state_t              state_q, state_d;
  logic [63:0]         grid_q, grid_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [1:0]          cause_q, cause_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] last;
  // >= rather than == so a live decrease of period below the running timer still fires
  assign last = (period == '0) ? '0 : period - 1'b1;
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    gen_d   = gen_q;
    cause_d = cause_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:    state_d = start ? SEED : IDLE;
      SEED:    state_d = LOAD;
      LOAD: begin
        grid_d  = lfsr_out;
        gen_d   = '0;
        cause_d = 2'b00;
        state_d = PRESENT;
      end
      PRESENT: state_d = frame.frame_ready ? CHECK : PRESENT;
      CHECK: begin
        if (grid_q == '0) begin
          cause_d = 2'b01;
          state_d = DONE;
        end else if (max_gen != '0 && gen_q == max_gen) begin
          cause_d = 2'b11;
          state_d = DONE;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!pause) begin
          timer_d = timer_q + 1'b1;
          state_d = (timer_q >= last) ? EVOLVE : WAIT;
        end else begin
          state_d = step ? EVOLVE : WAIT;
        end
      end
      EVOLVE: begin
        if (grid_next == grid_q) begin
          cause_d = 2'b10;
          state_d = DONE;
        end else begin
          grid_d  = grid_next;
          gen_d   = gen_q + 1'b1;
          state_d = PRESENT;
        end
      end
      DONE:    state_d = start ? SEED : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grid_q  <= '0;
      gen_q   <= '0;
      cause_q <= 2'b00;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      gen_q   <= gen_d;
      cause_q <= cause_d;
      timer_q <= timer_d;
    end
  end
  assign lfsr_reset        = state_q == SEED;
  assign frame.frame_valid = state_q == PRESENT;
  assign frame.grid        = grid_q;
  assign gen_count         = gen_q;
  assign busy              = state_q != IDLE && state_q != DONE;
  assign done              = state_q == DONE;
  assign done_cause        = cause_q;
endmodule
